// File: rtl/instruction_prefetch_queue_if.sv
// Bundles the instruction-memory handshake and the decode-side queue interface
// of the instruction prefetch queue. The master modport is the queue itself;
// the slave modport is the surrounding memory and decode environment.
interface instruction_prefetch_queue_if #(
    parameter int XLEN = 32
);
    logic            o_ImemReqValid;
    logic [XLEN-1:0] o_ImemAddr;
    logic            i_ImemReqReady;
    logic            i_ImemRespValid;
    logic [XLEN-1:0] i_ImemRespData;
    logic            i_Redirect;
    logic [XLEN-1:0] i_RedirectTarget;
    logic            o_Valid;
    logic [XLEN-1:0] o_PC;
    logic [XLEN-1:0] o_NextPC;
    logic [XLEN-1:0] o_InstructionWord;
    logic            o_InstructionAddressMisaligned;
    logic            i_Ready;

    modport master (
        output o_ImemReqValid, o_ImemAddr,
        input  i_ImemReqReady, i_ImemRespValid, i_ImemRespData,
        input  i_Redirect, i_RedirectTarget,
        output o_Valid, o_PC, o_NextPC, o_InstructionWord, o_InstructionAddressMisaligned,
        input  i_Ready
    );

    modport slave (
        input  o_ImemReqValid, o_ImemAddr,
        output i_ImemReqReady, i_ImemRespValid, i_ImemRespData,
        output i_Redirect, i_RedirectTarget,
        input  o_Valid, o_PC, o_NextPC, o_InstructionWord, o_InstructionAddressMisaligned,
        output i_Ready
    );
endinterface

// File: rtl/instruction_prefetch_queue.sv
// Instruction prefetch queue: keeps up to DEPTH in-order requests in flight to
// instruction memory and buffers the returned words in a DEPTH-entry FIFO that
// feeds decode. Redirects flush the FIFO and turn every outstanding request
// into a response that must be discarded.

// Protocol and invariant checks on the queue's internal counters.
module instruction_prefetch_queue_checker #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst_n,
    input logic          resp_valid,
    input logic [CW-1:0] inflight,
    input logic [CW-1:0] discard,
    input logic [CW-1:0] count
);
    // A response may only arrive while at least one request is outstanding.
    resp_needs_request: assert property (@(posedge clk) disable iff (!rst_n)
        resp_valid |-> (inflight != {CW{1'b0}}));

    // Counters stay within the credit window.
    inflight_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        inflight <= CW'(DEPTH));
    count_bounded: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));
    discard_within_inflight: assert property (@(posedge clk) disable iff (!rst_n)
        discard <= inflight);
endmodule

module instruction_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input logic                        i_Clock,
    input logic                        i_Reset,
    instruction_prefetch_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] entry_pc_r   [DEPTH];
    logic [XLEN-1:0] entry_word_r [DEPTH];
    logic [DEPTH-1:0] entry_mis_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW-1:0]   wr_ptr_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   inflight_r;
    logic [CW-1:0]   discard_r;
    logic            halted_r;

    logic            aligned_s;
    logic            credit_s;
    logic            req_valid_s;
    logic            req_fire_s;
    logic            resp_s;
    logic            pop_s;
    logic            push_s;
    logic            mark_s;
    logic [XLEN-1:0] push_pc_s;
    logic [XLEN-1:0] push_word_s;
    logic            push_mis_s;
    logic [CW-1:0]   inflight_nxt_s;
    logic [CW-1:0]   count_nxt_s;

    // Wrapping PC increment shared by fetch and the head NextPC output.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    assign aligned_s   = (pc_r[1:0] == 2'b00);
    // Buffered entries plus outstanding requests must never exceed the FIFO size,
    // so every response is guaranteed a free slot.
    assign credit_s    = ({1'b0, count_r} + {1'b0, inflight_r}) < (CW + 1)'(DEPTH);
    // Reset gating keeps the request line low during reset even though the
    // fetch state already holds RESET_PC.
    assign req_valid_s = i_Reset && !halted_r && !bus.i_Redirect && aligned_s && credit_s;
    assign req_fire_s  = req_valid_s && bus.i_ImemReqReady;
    assign resp_s      = bus.i_ImemRespValid;
    assign pop_s       = (count_r != {CW{1'b0}}) && bus.i_Ready;

    // Outstanding count after this cycle's request and response.
    assign inflight_nxt_s = inflight_r + {{AW{1'b0}}, req_fire_s} - {{AW{1'b0}}, resp_s};
    assign count_nxt_s    = count_r + {{AW{1'b0}}, push_s} - {{AW{1'b0}}, pop_s};

    // Select what, if anything, enters the FIFO this cycle: a live response word
    // (tagged with the PC of the oldest outstanding request) or a misalignment marker.
    always_comb begin
        push_s      = 1'b0;
        mark_s      = 1'b0;
        push_pc_s   = pc_r;
        push_word_s = {XLEN{1'b0}};
        push_mis_s  = 1'b0;
        if (resp_s) begin
            if (discard_r == {CW{1'b0}}) begin
                push_s      = 1'b1;
                push_pc_s   = pc_r - (XLEN'(inflight_r) << 2);
                push_word_s = bus.i_ImemRespData;
            end else begin
                push_s = 1'b0;
            end
        end else if (!halted_r && !aligned_s && (inflight_r == {CW{1'b0}})
                     && (discard_r == {CW{1'b0}}) && (count_r < CW'(DEPTH))) begin
            push_s     = 1'b1;
            mark_s     = 1'b1;
            push_pc_s  = pc_r;
            push_mis_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Fetch PC, FIFO pointers and the credit/discard bookkeeping; a redirect
    // overrides every other update.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            pc_r       <= RESET_PC;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            inflight_r <= {CW{1'b0}};
            discard_r  <= {CW{1'b0}};
            halted_r   <= 1'b0;
        end else if (bus.i_Redirect) begin
            pc_r       <= bus.i_RedirectTarget;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
            inflight_r <= inflight_nxt_s;
            discard_r  <= inflight_nxt_s;
            halted_r   <= 1'b0;
        end else begin
            pc_r       <= req_fire_s ? pc_plus4(pc_r) : pc_r;
            rd_ptr_r   <= pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
            wr_ptr_r   <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
            count_r    <= count_nxt_s;
            inflight_r <= inflight_nxt_s;
            discard_r  <= (resp_s && (discard_r != {CW{1'b0}})) ? discard_r - CW'(1) : discard_r;
            halted_r   <= halted_r || mark_s;
        end
    end

    // FIFO storage writes; nothing is written in a redirect cycle.
    always_ff @(posedge i_Clock or negedge i_Reset) begin
        if (!i_Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_pc_r[i]   <= {XLEN{1'b0}};
                entry_word_r[i] <= {XLEN{1'b0}};
            end
            entry_mis_r <= {DEPTH{1'b0}};
        end else if (push_s && !bus.i_Redirect) begin
            entry_pc_r[wr_ptr_r]   <= push_pc_s;
            entry_word_r[wr_ptr_r] <= push_word_s;
            entry_mis_r[wr_ptr_r]  <= push_mis_s;
        end
    end

    assign bus.o_ImemReqValid                 = req_valid_s;
    assign bus.o_ImemAddr                     = pc_r;
    assign bus.o_Valid                        = (count_r != {CW{1'b0}});
    assign bus.o_PC                           = entry_pc_r[rd_ptr_r];
    assign bus.o_NextPC                       = pc_plus4(entry_pc_r[rd_ptr_r]);
    assign bus.o_InstructionWord              = entry_word_r[rd_ptr_r];
    assign bus.o_InstructionAddressMisaligned = (count_r != {CW{1'b0}}) && entry_mis_r[rd_ptr_r];

    instruction_prefetch_queue_checker #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_checker (
        .clk        (i_Clock),
        .rst_n      (i_Reset),
        .resp_valid (bus.i_ImemRespValid),
        .inflight   (inflight_r),
        .discard    (discard_r),
        .count      (count_r)
    );
endmodule

// File: doc/instruction_prefetch_queue.md
Name: instruction_prefetch_queue

Overview:
Parameterised successor to the single-word instruction fetch stage. It decouples fetch from decode with a DEPTH-entry prefetch FIFO and keeps up to DEPTH requests in flight to a variable-latency, in-order instruction memory. Decode-stage redirects flush the queue, discard stale in-flight responses and restart fetch at the target. It sits between instruction memory and stage_instruction_decode, and provides PC, NextPC, InstructionWord and a misalignment flag per entry.

Parameters:
XLEN, 32, address/data width
DEPTH, 4, FIFO entries and max outstanding requests; power of two, >=2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
i_Clock  in  1  clock, rising edge
i_Reset  in  1  asynchronous, active-low reset
o_ImemReqValid  out  1  request valid
o_ImemAddr  out  XLEN  request address (current fetch PC)
i_ImemReqReady  in  1  memory accepts request
i_ImemRespValid  in  1  response valid; responses arrive in request order
i_ImemRespData  in  XLEN  response instruction word
i_Redirect  in  1  branch/jump redirect from decode
i_RedirectTarget  in  XLEN  redirect PC
o_Valid  out  1  queue head valid
o_PC  out  XLEN  head entry PC
o_NextPC  out  XLEN  head entry PC+4 (wraps modulo 2^XLEN)
o_InstructionWord  out  XLEN  head entry word
o_InstructionAddressMisaligned  out  1  head entry is a misaligned-fetch marker
i_Ready  in  1  decode consumes head this cycle

Behaviour:
- State: fetch PC, FIFO storage, rd/wr pointers, count (clog2(DEPTH)+1 bits), inflight counter, discard counter, halted flag.
- Reset (i_Reset=0, async): PC=RESET_PC, count=inflight=discard=0, halted=0. Outputs: o_Valid=0, o_ImemReqValid=0, o_ImemAddr=RESET_PC, o_InstructionAddressMisaligned=0. The first request can assert in the first cycle after reset deasserts.
- Issue: o_ImemReqValid = !halted && !i_Redirect && PC[1:0]==0 && (count+inflight < DEPTH). On valid&&ready: inflight+=1, PC+=4 (wrap). Address is held stable while valid && !ready.
- Response: if discard>0, drop the word and decrement discard. Otherwise push {PC of oldest in-flight request, word, misaligned=0}. Either way inflight-=1. Entry PC is tracked via an in-flight PC FIFO or the equivalent PC-minus-4*(inflight) arithmetic. Credit rule guarantees a push never meets a full FIFO.
- Pop: o_Valid = count!=0. o_Valid&&i_Ready advances the head. Push and pop in the same cycle leaves count unchanged.
- Head outputs are driven from registered FIFO state; no combinational path from i_ImemResp* to o_*.
- Redirect (i_Redirect=1), which has priority over all else:
  - Next cycle: count=0, PC=i_RedirectTarget, halted=0.
  - discard = inflight + (request accepted this cycle ? 1 : 0) − (response this cycle ? 1 : 0). No request is issued in the redirect cycle.
  - A response arriving in the redirect cycle is dropped.
  - i_Ready in the same cycle is ignored.
  - o_Valid=0 the cycle after.
- Misaligned PC (PC[1:0]!=0, not halted): no request issued. Once inflight==0 and discard==0, push one entry {PC, word=0, misaligned=1} and set halted. Fetch stays stalled until the next redirect. Requires a free FIFO slot; wait otherwise.
- Back-to-back redirects: each recomputes discard from the current counters; only the last target fetches.
- Inflight and discard never exceed DEPTH. A response with inflight==0 is a protocol violation; the assertion checks it in simulation.

Test Plan:
- Reset, then i_ImemReqReady=1, 1-cycle response latency, i_Ready=1 -> addresses 0,4,8,… issued every cycle; head PCs 0,4,8 in order; o_NextPC=PC+4.
- DEPTH=4, i_Ready=0 -> exactly 4 requests issued then o_ImemReqValid=0. Raise i_Ready -> entries 0,4,8,12 drain in order and fetch resumes at 16.
- 3-cycle latency, 3 requests in flight, redirect to 0x100 -> the 3 stale responses are dropped. First delivered entry is PC=0x100, word = memory[0x100].
- Redirect to 0x102 -> no request issued; one entry PC=0x102 with misaligned=1, word=0. No further entries until redirect to 0x200, which resumes normal fetch.
- Redirect coinciding with response and with i_Ready=1 -> response dropped, queue empty next cycle, discard count correct (no stale word delivered later).
- Assert i_Reset=0 mid-stream with requests in flight -> o_Valid and o_ImemReqValid low immediately. After release, fetch restarts at RESET_PC.
